// File: rtl/song_pkg.sv
// Shared types and field layout for the song sequencer.
// A song ROM entry is {dur, period}, and a dur of 0 marks the end of the song.
package song_pkg;

    localparam int ADDR_W   = 7;
    localparam int PERIOD_W = 15;
    localparam int DUR_W    = 8;
    localparam int ENTRY_W  = DUR_W + PERIOD_W;

    localparam int DUR_LSB    = PERIOD_W;
    localparam int PERIOD_MSB = PERIOD_W - 1;

    localparam logic [DUR_W-1:0] END_MARKER = '0;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        PLAY,
        GAP
    } state_t;

    function automatic logic [DUR_W-1:0] entry_dur(input logic [ENTRY_W-1:0] entry);
        return entry[ENTRY_W-1:DUR_LSB];
    endfunction

    function automatic logic [PERIOD_W-1:0] entry_period(input logic [ENTRY_W-1:0] entry);
        return entry[PERIOD_MSB:0];
    endfunction

endpackage

// File: rtl/song_sequencer_if.sv
// Song sequencer bus: play control, song ROM port and tone generator feed.
// The master side is the host plus ROM; the slave side is the sequencer.
interface song_sequencer_if;
    import song_pkg::*;

    logic                play;
    logic                stop;
    logic                loop;
    logic [ADDR_W-1:0]   rom_addr;
    logic [ENTRY_W-1:0]  rom_data;
    logic [PERIOD_W-1:0] note_value;
    logic                note_valid;
    logic                busy;
    logic                done;

    modport master (
        output play, stop, loop, rom_data,
        input  rom_addr, note_value, note_valid, busy, done
    );

    modport slave (
        input  play, stop, loop, rom_data,
        output rom_addr, note_value, note_valid, busy, done
    );

endinterface

// File: rtl/tempo_tick.sv
// Tempo prescaler: counts 0..TICK_DIV-1 and strobes tick on the last count.
// While clr is high the count is held at 0 and tick stays low.
module tempo_tick #(
    parameter int TICK_DIV = 20910
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = $clog2(TICK_DIV);

    logic [CNT_W-1:0] cnt;

    assign tick = !clr && (cnt == CNT_W'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/song_sequencer.sv
// Song sequencer: walks the song ROM and holds each note's half-period for its duration.
// Defining SONG_SEQ_NOTE_GAP_EN inserts GAP_CYCLES of silence after every note.
//
// state | meaning
// IDLE  | waiting for play; outputs silent
// FETCH | ROM address presented, data arrives next cycle
// LOAD  | decode entry: end marker, rest or note
// PLAY  | hold note for dur tempo ticks
// GAP   | forced silence between notes (gap build only)
module song_sequencer
    import song_pkg::*;
#(
    parameter int TICK_DIV   = 20910,
    parameter int GAP_CYCLES = 2000
) (
    input logic              clk,
    input logic              reset,
    song_sequencer_if.slave  bus
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   addr_q, addr_nxt;
    logic [PERIOD_W-1:0] value_q, value_nxt;
    logic                valid_q, valid_nxt;
    logic                done_q, done_nxt;
    logic                busy_q;
    logic [DUR_W-1:0]    dur_q, dur_nxt;
    logic [GAP_W-1:0]    gap_q, gap_nxt;
    logic                tick;
    logic                tick_clr;
    logic [DUR_W-1:0]    dur_in;
    logic [PERIOD_W-1:0] period_in;

    assign dur_in    = entry_dur(bus.rom_data);
    assign period_in = entry_period(bus.rom_data);

    // Holding the prescaler clear outside PLAY restarts every note on a tick boundary.
    assign tick_clr = (state != PLAY);

    tempo_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_tempo_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (tick_clr),
        .tick  (tick)
    );

    always_comb begin
        state_nxt = state;
        addr_nxt  = addr_q;
        value_nxt = value_q;
        valid_nxt = valid_q;
        done_nxt  = 1'b0;
        dur_nxt   = dur_q;
        gap_nxt   = gap_q;

        case (state)
            IDLE: begin
                if (bus.play) begin
                    state_nxt = FETCH;
                    addr_nxt  = '0;
                end
            end
            FETCH: state_nxt = LOAD;
            LOAD: begin
                if (dur_in == END_MARKER) begin
                    addr_nxt = '0;
                    if (bus.loop) begin
                        state_nxt = FETCH;
                    end else begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                        valid_nxt = 1'b0;
                    end
                end else begin
                    value_nxt = period_in;
                    valid_nxt = (period_in != '0);
                    dur_nxt   = dur_in;
                    state_nxt = PLAY;
                end
            end
            PLAY: begin
                if (tick) begin
                    dur_nxt = dur_q - 1'b1;
                    if (dur_q == DUR_W'(1)) begin
                        addr_nxt = addr_q + 1'b1;
`ifdef SONG_SEQ_NOTE_GAP_EN
                        state_nxt = GAP;
                        valid_nxt = 1'b0;
                        gap_nxt   = GAP_W'(GAP_CYCLES - 1);
`else
                        state_nxt = FETCH;
`endif
                    end
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_nxt = FETCH;
                end else begin
                    gap_nxt = gap_q - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // stop overrides everything, including a play in the same cycle
        if (bus.stop) begin
            state_nxt = IDLE;
            addr_nxt  = '0;
            valid_nxt = 1'b0;
            done_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            addr_q  <= '0;
            value_q <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            dur_q   <= '0;
            gap_q   <= '0;
        end else begin
            state   <= state_nxt;
            addr_q  <= addr_nxt;
            value_q <= value_nxt;
            valid_q <= valid_nxt;
            done_q  <= done_nxt;
            busy_q  <= (state_nxt != IDLE);
            dur_q   <= dur_nxt;
            gap_q   <= gap_nxt;
        end
    end

    assign bus.rom_addr   = addr_q;
    assign bus.note_value = value_q;
    assign bus.note_valid = valid_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer with TICK_DIV=4, GAP_CYCLES=3.
// Expected traces follow SONG_SEQ_NOTE_GAP_EN so the same bench covers both builds.
module tb_song_sequencer;
    import song_pkg::*;

    logic clk;
    logic reset;

    song_sequencer_if bus();

    song_sequencer #(
        .TICK_DIV   (4),
        .GAP_CYCLES (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [ENTRY_W-1:0] rom [0:127];
    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    typedef struct {
        int                  id;
        int                  first;
        int                  last;
        logic                valid;
        logic [PERIOD_W-1:0] value;
        logic                busy;
        logic                done;
        logic [ADDR_W-1:0]   addr;
    } seg_t;

    seg_t segs[$];
    int   n_checks = 0;
    int   n_errors = 0;

`ifdef SONG_SEQ_NOTE_GAP_EN
    localparam int N1 = 28;
    localparam int N2 = 34;
    localparam int N6 = 23;
`else
    localparam int N1 = 22;
    localparam int N2 = 28;
    localparam int N6 = 17;
`endif

    task automatic add(input int id, input int first, input int last, input logic valid,
                       input int value, input logic busy, input logic done, input int addr);
        seg_t s;
        s.id    = id;
        s.first = first;
        s.last  = last;
        s.valid = valid;
        s.value = PERIOD_W'(value);
        s.busy  = busy;
        s.done  = done;
        s.addr  = ADDR_W'(addr);
        segs.push_back(s);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_cycle(input int id, input int c);
        bit found = 0;
        foreach (segs[i]) begin
            if (segs[i].id == id && c >= segs[i].first && c <= segs[i].last) begin
                found = 1;
                chk($sformatf("t%0d c%0d note_valid", id, c), 32'(bus.note_valid), 32'(segs[i].valid));
                chk($sformatf("t%0d c%0d note_value", id, c), 32'(bus.note_value), 32'(segs[i].value));
                chk($sformatf("t%0d c%0d busy", id, c), 32'(bus.busy), 32'(segs[i].busy));
                chk($sformatf("t%0d c%0d done", id, c), 32'(bus.done), 32'(segs[i].done));
                chk($sformatf("t%0d c%0d rom_addr", id, c), 32'(bus.rom_addr), 32'(segs[i].addr));
            end
        end
        if (!found) begin
            n_checks++;
            n_errors++;
            $display("FAIL t%0d c%0d: no vector covers this cycle", id, c);
        end
    endtask

    task automatic pulse_play();
        bus.play = 1'b1;
        @(negedge clk);
        bus.play = 1'b0;
    endtask

    task automatic stop_and_check(input string name);
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        chk({name, " stop busy"}, 32'(bus.busy), 32'd0);
        chk({name, " stop valid"}, 32'(bus.note_valid), 32'd0);
    endtask

    // Caller sits on a negedge; cycle c is the c-th negedge after play was set.
    task automatic run_table(input int id, input int ncyc, input logic lp);
        bus.loop = lp;
        pulse_play();
        for (int c = 1; c <= ncyc; c++) begin
            check_cycle(id, c);
            @(negedge clk);
        end
        bus.loop = 1'b0;
        stop_and_check($sformatf("t%0d", id));
    endtask

    task automatic load_rom_song1();
        for (int i = 0; i < 128; i++) rom[i] = '0;
        rom[0] = {8'd2, 15'd100};
        rom[1] = {8'd1, 15'd0};
        rom[2] = {8'd0, 15'd123};
    endtask

    task automatic check_idle_outputs(input string name);
        chk({name, " note_valid"}, 32'(bus.note_valid), 32'd0);
        chk({name, " note_value"}, 32'(bus.note_value), 32'd0);
        chk({name, " busy"}, 32'(bus.busy), 32'd0);
        chk({name, " done"}, 32'(bus.done), 32'd0);
        chk({name, " rom_addr"}, 32'(bus.rom_addr), 32'd0);
    endtask

    initial begin
        int n;

        reset    = 1'b1;
        bus.play = 1'b0;
        bus.stop = 1'b0;
        bus.loop = 1'b0;

`ifdef SONG_SEQ_NOTE_GAP_EN
        add(1,  1,  2, 0,   0, 1, 0, 0);
        add(1,  3, 10, 1, 100, 1, 0, 0);
        add(1, 11, 15, 0, 100, 1, 0, 1);
        add(1, 16, 19, 0,   0, 1, 0, 1);
        add(1, 20, 24, 0,   0, 1, 0, 2);
        add(1, 25, 25, 0,   0, 0, 1, 0);
        add(1, 26, 28, 0,   0, 0, 0, 0);
        add(2,  1,  2, 0,   0, 1, 0, 0);
        add(2,  3, 10, 1, 100, 1, 0, 0);
        add(2, 11, 15, 0, 100, 1, 0, 1);
        add(2, 16, 19, 0,   0, 1, 0, 1);
        add(2, 20, 24, 0,   0, 1, 0, 2);
        add(2, 25, 26, 0,   0, 1, 0, 0);
        add(2, 27, 34, 1, 100, 1, 0, 0);
        add(6,  1,  2, 0,   0, 1, 0, 0);
        add(6,  3,  6, 1, 100, 1, 0, 0);
        add(6,  7, 11, 0, 100, 1, 0, 1);
        add(6, 12, 15, 1, 100, 1, 0, 1);
        add(6, 16, 20, 0, 100, 1, 0, 2);
        add(6, 21, 21, 0, 100, 0, 1, 0);
        add(6, 22, 23, 0, 100, 0, 0, 0);
`else
        add(1,  1,  2, 0,   0, 1, 0, 0);
        add(1,  3, 10, 1, 100, 1, 0, 0);
        add(1, 11, 12, 1, 100, 1, 0, 1);
        add(1, 13, 16, 0,   0, 1, 0, 1);
        add(1, 17, 18, 0,   0, 1, 0, 2);
        add(1, 19, 19, 0,   0, 0, 1, 0);
        add(1, 20, 22, 0,   0, 0, 0, 0);
        add(2,  1,  2, 0,   0, 1, 0, 0);
        add(2,  3, 10, 1, 100, 1, 0, 0);
        add(2, 11, 12, 1, 100, 1, 0, 1);
        add(2, 13, 16, 0,   0, 1, 0, 1);
        add(2, 17, 18, 0,   0, 1, 0, 2);
        add(2, 19, 20, 0,   0, 1, 0, 0);
        add(2, 21, 28, 1, 100, 1, 0, 0);
        add(6,  1,  2, 0,   0, 1, 0, 0);
        add(6,  3,  6, 1, 100, 1, 0, 0);
        add(6,  7, 12, 1, 100, 1, 0, 1);
        add(6, 13, 14, 1, 100, 1, 0, 2);
        add(6, 15, 15, 0, 100, 0, 1, 0);
        add(6, 16, 17, 0, 100, 0, 0, 0);
`endif

        load_rom_song1();
        #2;
        check_idle_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("post_reset");

        // 1: single play of note + rest + end marker
        run_table(1, N1, 1'b0);

        // 2: looping song returns to address 0 without done
        run_table(2, N2, 1'b1);

        // 3: stop mid-note, then play+stop together from IDLE
        pulse_play();
        for (int c = 1; c < 5; c++) @(negedge clk);
        chk("t3 playing before stop", 32'(bus.note_valid), 32'd1);
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        chk("t3 stop busy", 32'(bus.busy), 32'd0);
        chk("t3 stop valid", 32'(bus.note_valid), 32'd0);
        chk("t3 stop addr", 32'(bus.rom_addr), 32'd0);
        for (int c = 0; c < 3; c++) begin
            chk("t3 no done", 32'(bus.done), 32'd0);
            @(negedge clk);
        end
        bus.play = 1'b1;
        bus.stop = 1'b1;
        @(negedge clk);
        bus.play = 1'b0;
        bus.stop = 1'b0;
        chk("t3 play+stop busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        chk("t3 play+stop still idle", 32'(bus.busy), 32'd0);

        // 4: no end marker, address wraps 127 -> 0; play while busy ignored
        for (int i = 0; i < 128; i++) rom[i] = {8'd1, 15'd50};
        pulse_play();
        n = 0;
        while (bus.rom_addr != 7'd5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t4 reach addr 5", 32'(bus.rom_addr), 32'd5);
        pulse_play();
        chk("t4 play while busy addr", 32'(bus.rom_addr), 32'd5);
        chk("t4 play while busy busy", 32'(bus.busy), 32'd1);
        n = 0;
        while (bus.rom_addr != 7'd127 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("t4 reach addr 127", 32'(bus.rom_addr), 32'd127);
        n = 0;
        while (bus.rom_addr != 7'd0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t4 wrap addr", 32'(bus.rom_addr), 32'd0);
        chk("t4 wrap busy", 32'(bus.busy), 32'd1);
        chk("t4 wrap no done", 32'(bus.done), 32'd0);
        n = 0;
        while (!(bus.note_valid && bus.note_value == 15'd50) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t4 after wrap valid", 32'(bus.note_valid), 32'd1);
        chk("t4 after wrap value", 32'(bus.note_value), 32'd50);
        stop_and_check("t4");

        // 5: asynchronous reset in the middle of a note
        load_rom_song1();
        pulse_play();
        for (int c = 1; c < 5; c++) @(negedge clk);
        chk("t5 playing before reset", 32'(bus.note_valid), 32'd1);
        #1 reset = 1'b1;
        #1 check_idle_outputs("t5 async reset");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_table(1, N1, 1'b0);

        // 6: two identical notes, with or without the silence gap
        for (int i = 0; i < 128; i++) rom[i] = '0;
        rom[0] = {8'd1, 15'd100};
        rom[1] = {8'd1, 15'd100};
        rom[2] = {8'd0, 15'd77};
        run_table(6, N6, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
